stop_watch_ctrl: RTL and testbench
==================================

STOP_WATCH_CTRL -- requirements
Module: stop_watch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per stopwatch count tick; legal range 2 and above.
REQ-002 clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 btn_ss  input  1  start/stop request, one-cycle pulse, already debounced.
REQ-005 btn_lr  input  1  lap/reset request, one-cycle pulse, already debounced.
REQ-006 cur_second, cur_minute, cur_hour  input  8 each  live count from the stopwatch counter.
REQ-007 sw_en  output  1  one-cycle count enable to the counter's start input.
REQ-008 sw_clr  output  1  one-cycle clear pulse to the counter's reset input.
REQ-009 state  output  2  current FSM state (encoding per REQ-011).
REQ-010 disp_second, disp_minute, disp_hour  output  8 each  values to display.

Function
REQ-011 FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-012 IDLE: btn_ss -> RUN; btn_lr ignored.
REQ-013 RUN: btn_ss -> PAUSE; btn_lr -> LAP, capturing cur_* into the lap registers on the same edge.
REQ-014 LAP: btn_ss -> PAUSE with the lap registers retained; btn_lr -> RUN, releasing the freeze.
REQ-015 PAUSE: btn_ss -> RUN; btn_lr -> IDLE, with sw_clr high for exactly the next cycle.
REQ-016 If btn_ss and btn_lr are high in the same cycle, btn_ss wins and btn_lr is discarded.
REQ-017 Prescaler: a $clog2(TICK_DIV)-bit counter.
REQ-018 Prescaler increments every cycle in RUN or LAP.
REQ-019 Prescaler holds its value in PAUSE, so a resumed run completes the partial second.
REQ-020 Prescaler is forced to 0 in IDLE.
REQ-021 When the prescaler equals TICK_DIV-1 in RUN or LAP, it wraps to 0 and sw_en is registered high for exactly one cycle.
REQ-022 If the prescaler reaches TICK_DIV-1 on the same edge that leaves RUN or LAP for PAUSE, the tick is still issued and the prescaler wraps to 0.
REQ-023 sw_en is never high in IDLE or PAUSE except for the final tick allowed by REQ-022.
REQ-024 sw_en and sw_clr are registered: they are high in the cycle after the triggering edge and are never high in the same cycle.
REQ-025 In LAP, disp_* equal the lap registers; in all other states, disp_* equal cur_* combinationally.
REQ-026 The lap registers are written only on a RUN->LAP transition; they are cleared on the PAUSE->IDLE transition.

Reset
REQ-027 While rst_n is low at a rising clk edge, the block SHALL load: state=IDLE, prescaler=0, sw_en=0, sw_clr=0, lap registers=0.
REQ-028 A reset asserted mid-RUN SHALL cancel any pending tick.
REQ-029 In the first cycle after reset release, disp_* SHALL equal cur_*.

Structure
REQ-030 A shared package SHALL hold the state enumeration/localparams (IDLE, RUN, PAUSE, LAP) and the 8-bit time-field width constant, both used by the top-level clock module.
REQ-031 The prescaler SHALL be a separate sub-module, tick_prescaler, with ports clk, rst_n, run, clr, and tick.
REQ-032 The FSM, lap registers and display mux SHALL reside in stop_watch_ctrl.

Verification
REQ-033 TICK_DIV=4; reset; btn_ss pulse -> state=RUN; sw_en pulses every 4th cycle, the first pulse 4 cycles after entering RUN.
REQ-034 RUN for 6 cycles (prescaler=2), then btn_ss -> PAUSE with no sw_en for 20 cycles; then btn_ss -> first sw_en 2 cycles after re-entering RUN.
REQ-035 RUN with cur_*={0,1,5} at the btn_lr edge -> state=LAP and disp_*={0,1,5} held while cur_* advances; then btn_lr -> state=RUN and disp_* track cur_*.
REQ-036 PAUSE, then btn_lr -> state=IDLE, sw_clr high for exactly 1 cycle, lap registers=0; a btn_lr pulse while in IDLE -> no sw_clr and no state change.
REQ-037 In RUN, btn_ss and btn_lr in the same cycle -> state=PAUSE and lap registers unchanged.
REQ-038 rst_n low for 1 cycle while in LAP at prescaler=3 -> next cycle state=IDLE, sw_en=0, disp_*=cur_*.

Source files
------------

// File: rtl/stop_watch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice.
package stop_watch_ctrl_pkg;

  localparam int unsigned TIME_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

endpackage

// File: rtl/stop_watch_ctrl_prescaler.sv
// Count-tick prescaler: divides clk by TICK_DIV while running, holds when
// stopped, and returns to zero when cleared.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Advance while running and emit a registered one-cycle tick on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control: start/stop and lap/reset FSM, lap capture registers,
// display selection, and the count-enable prescaler.
module stop_watch_ctrl
  import stop_watch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [TIME_W-1:0] cur_second,
  input  logic [TIME_W-1:0] cur_minute,
  input  logic [TIME_W-1:0] cur_hour,
  output logic              sw_en,
  output logic              sw_clr,
  output logic [1:0]        state,
  output logic [TIME_W-1:0] disp_second,
  output logic [TIME_W-1:0] disp_minute,
  output logic [TIME_W-1:0] disp_hour
);

  sw_state_e cur_state, nxt_state;

  logic [TIME_W-1:0] lap_second, lap_minute, lap_hour;
  logic              lap_capture, lap_clear, clr_nxt;
  logic              pre_run, pre_clr;

  // State register, lap registers and the registered clear pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state  <= IDLE;
      sw_clr     <= 1'b0;
      lap_second <= '0;
      lap_minute <= '0;
      lap_hour   <= '0;
    end else begin
      cur_state <= nxt_state;
      sw_clr    <= clr_nxt;
      if (lap_clear) begin
        lap_second <= '0;
        lap_minute <= '0;
        lap_hour   <= '0;
      end else if (lap_capture) begin
        lap_second <= cur_second;
        lap_minute <= cur_minute;
        lap_hour   <= cur_hour;
      end
    end
  end

  // Next-state decode; start/stop takes priority over lap/reset.
  always_comb begin
    nxt_state   = cur_state;
    lap_capture = 1'b0;
    lap_clear   = 1'b0;
    clr_nxt     = 1'b0;
    unique case (cur_state)
      IDLE: begin
        if (btn_ss) nxt_state = RUN;
      end
      RUN: begin
        if (btn_ss) begin
          nxt_state = PAUSE;
        end else if (btn_lr) begin
          nxt_state   = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (btn_ss) nxt_state = PAUSE;
        else if (btn_lr) nxt_state = RUN;
      end
      PAUSE: begin
        if (btn_ss) begin
          nxt_state = RUN;
        end else if (btn_lr) begin
          nxt_state = IDLE;
          lap_clear = 1'b1;
          clr_nxt   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Prescaler control follows the current state, so the edge leaving
  // RUN/LAP still counts and may issue the final tick.
  always_comb begin
    pre_run = (cur_state == RUN) || (cur_state == LAP);
    pre_clr = (cur_state == IDLE);
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (pre_run),
    .clr   (pre_clr),
    .tick  (sw_en)
  );

  // Display shows the frozen lap values only while in LAP.
  always_comb begin
    state = cur_state;
    if (cur_state == LAP) begin
      disp_second = lap_second;
      disp_minute = lap_minute;
      disp_hour   = lap_hour;
    end else begin
      disp_second = cur_second;
      disp_minute = cur_minute;
      disp_hour   = cur_hour;
    end
  end

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Self-checking bench for stop_watch_ctrl with TICK_DIV=4.
module tb_stop_watch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [7:0] cur_second = '0, cur_minute = '0, cur_hour = '0;
  logic       sw_en, sw_clr;
  logic [1:0] state;
  logic [7:0] disp_second, disp_minute, disp_hour;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  stop_watch_ctrl #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_ss      (btn_ss),
    .btn_lr      (btn_lr),
    .cur_second  (cur_second),
    .cur_minute  (cur_minute),
    .cur_hour    (cur_hour),
    .sw_en       (sw_en),
    .sw_clr      (sw_clr),
    .state       (state),
    .disp_second (disp_second),
    .disp_minute (disp_minute),
    .disp_hour   (disp_hour)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode as an integer, prescaler as a modulo count,
  // lap snapshot as a small array {hour, minute, second}.
  int m_mode = 0;   // 0 idle, 1 run, 2 pause, 3 lap
  int m_pre = 0;
  int m_en = 0;
  int m_clr = 0;
  int m_lap[3] = '{0, 0, 0};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pre = 0; m_en = 0; m_clr = 0;
      m_lap = '{0, 0, 0};
    end else begin
      m_en = 0;
      m_clr = 0;
      if (m_mode == 1 || m_mode == 3) begin
        m_en = (m_pre == TD - 1) ? 1 : 0;
        m_pre = (m_pre + 1) % TD;
      end else if (m_mode == 0) begin
        m_pre = 0;
      end
      if (btn_ss) begin
        m_mode = (m_mode == 0 || m_mode == 2) ? 1 : 2;
      end else if (btn_lr) begin
        if (m_mode == 1) begin
          m_mode = 3;
          m_lap = '{int'(cur_hour), int'(cur_minute), int'(cur_second)};
        end else if (m_mode == 3) begin
          m_mode = 1;
        end else if (m_mode == 2) begin
          m_mode = 0; m_clr = 1;
          m_lap = '{0, 0, 0};
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      int eh, em, es;
      eh = (m_mode == 3) ? m_lap[0] : int'(cur_hour);
      em = (m_mode == 3) ? m_lap[1] : int'(cur_minute);
      es = (m_mode == 3) ? m_lap[2] : int'(cur_second);
      chk("cyc_state", int'(state), m_mode);
      chk("cyc_sw_en", int'(sw_en), m_en);
      chk("cyc_sw_clr", int'(sw_clr), m_clr);
      chk("cyc_disp_h", int'(disp_hour), eh);
      chk("cyc_disp_m", int'(disp_minute), em);
      chk("cyc_disp_s", int'(disp_second), es);
      chk("cyc_en_clr_excl", int'(sw_en & sw_clr), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic ss, input logic lr);
    btn_ss = ss; btn_lr = lr;
    @(posedge clk); #1;
    btn_ss = 1'b0; btn_lr = 1'b0;
  endtask

  // Cycles until sw_en is seen, bounded; -1 if it never arrives.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (sw_en) begin n = i; break; end
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 8'(h); cur_minute = 8'(m); cur_second = 8'(s);
  endtask

  initial begin
    int n, en_seen;
    set_cur(0, 0, 3);
    step(2);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_sw_en", int'(sw_en), 0);
    chk("rst_sw_clr", int'(sw_clr), 0);
    chk("rst_disp_s", int'(disp_second), 3);

    // Start, tick cadence.
    pulse(1'b1, 1'b0);
    chk("start_state", int'(state), 1);
    wait_tick(n);
    chk("first_tick_lat", n, 4);
    wait_tick(n);
    chk("tick_period", n, 4);

    // Pause with prescaler at 2, no ticks, resume completes partial count.
    step(1);
    pulse(1'b1, 1'b0);
    chk("pause_state", int'(state), 2);
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin step(1); en_seen += int'(sw_en); end
    chk("pause_no_tick", en_seen, 0);
    pulse(1'b1, 1'b0);
    chk("resume_state", int'(state), 1);
    wait_tick(n);
    chk("resume_tick_lat", n, 2);

    // Lap freeze and release.
    set_cur(0, 1, 5);
    pulse(1'b0, 1'b1);
    chk("lap_state", int'(state), 3);
    chk("lap_disp_s", int'(disp_second), 5);
    chk("lap_disp_m", int'(disp_minute), 1);
    set_cur(0, 1, 6);
    step(1);
    chk("lap_hold_s", int'(disp_second), 5);
    pulse(1'b0, 1'b1);
    chk("unlap_state", int'(state), 1);
    chk("unlap_disp_s", int'(disp_second), 6);
    set_cur(0, 1, 7);
    #1;
    chk("unlap_track_s", int'(disp_second), 7);

    // Simultaneous buttons in RUN: stop wins, lap registers untouched.
    set_cur(0, 2, 8);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    set_cur(0, 3, 9);
    pulse(1'b1, 1'b1);
    chk("both_state", int'(state), 2);
    chk("both_lap_s", int'(dut.lap_second), 8);
    chk("both_lap_m", int'(dut.lap_minute), 2);

    // PAUSE -> IDLE clear pulse, then lap/reset ignored in IDLE.
    pulse(1'b0, 1'b1);
    chk("clr_state", int'(state), 0);
    chk("clr_pulse", int'(sw_clr), 1);
    chk("clr_lap_s", int'(dut.lap_second), 0);
    step(1);
    chk("clr_pulse_end", int'(sw_clr), 0);
    pulse(1'b0, 1'b1);
    chk("idle_lr_state", int'(state), 0);
    chk("idle_lr_clr", int'(sw_clr), 0);

    // Stop on the wrap edge still issues the tick.
    pulse(1'b1, 1'b0);
    step(3);
    pulse(1'b1, 1'b0);
    chk("edge_pause_state", int'(state), 2);
    chk("edge_pause_tick", int'(sw_en), 1);
    step(1);
    chk("edge_pause_tick_end", int'(sw_en), 0);

    // Reset in LAP with prescaler at 3 cancels the pending tick.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    chk("rst2_run", int'(state), 1);
    set_cur(0, 4, 11);
    pulse(1'b0, 1'b1);
    step(2);
    chk("rst2_lap", int'(state), 3);
    set_cur(0, 4, 12);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst2_state", int'(state), 0);
    chk("rst2_sw_en", int'(sw_en), 0);
    chk("rst2_disp_s", int'(disp_second), 12);
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin step(1); en_seen += int'(sw_en); end
    chk("rst2_no_tick", en_seen, 0);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1 (run did not complete)");
    $fatal(1, "timeout");
  end

endmodule
